// File: rtl/track_pool.sv
// Pools a latched 52x52 stroke bitmap into a 13x13 image, one output cell per cycle,
// and holds the result under valid/ready. Define TRACK_POOL_THRESH_EN for count-threshold pooling.
module track_pool #(
  parameter int BLKSIZE = 52,
  parameter int POOL    = 4,
  parameter int GRID    = 13,
  parameter int THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [BLKSIZE*BLKSIZE-1:0]   track,
  input  logic [3:0]                   block_x,
  input  logic [3:0]                   block_y,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [GRID*GRID-1:0]         img,
  output logic [7:0]                   pix_count,
  output logic [3:0]                   out_block_x,
  output logic [3:0]                   out_block_y,
  output logic                         busy,
  output logic                         overrun
);

  localparam int NPIX   = BLKSIZE * BLKSIZE;
  localparam int NCELL  = GRID * GRID;
  localparam int CNT_W  = $clog2(GRID);
  localparam int WIN_W  = $clog2(POOL * POOL + 1);
  localparam int IDX_W  = (NPIX > 4096) ? $clog2(NPIX) : 12;
  localparam int CELL_W = $clog2(NCELL);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [NPIX-1:0]    buf_q;
  logic [CNT_W-1:0]   r_q, c_q;
  logic [WIN_W-1:0]   win_count;
  logic               cell_bit;
  logic               last_cell;
  logic [CELL_W-1:0]  cell_idx;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign last_cell = (r_q == CNT_W'(GRID - 1)) && (c_q == CNT_W'(GRID - 1));

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = SCAN;
      SCAN:    if (last_cell) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == HOLD);
  end

  // Window of buffer rows POOL*r.., columns POOL*c..; pixel index is row*BLKSIZE + col
  always_comb begin
    win_count = '0;
    for (int i = 0; i < POOL; i++) begin
      for (int j = 0; j < POOL; j++) begin
        logic [IDX_W-1:0] idx;
        idx = (IDX_W'(POOL) * IDX_W'(r_q) + IDX_W'(i)) * IDX_W'(BLKSIZE)
            + IDX_W'(POOL) * IDX_W'(c_q) + IDX_W'(j);
        win_count = win_count + WIN_W'(buf_q[idx]);
      end
    end
  end

`ifdef TRACK_POOL_THRESH_EN
  assign cell_bit = (win_count >= WIN_W'(THRESH));
`else
  assign cell_bit = (win_count != '0);
`endif

  assign cell_idx = CELL_W'(r_q) * CELL_W'(GRID) + CELL_W'(c_q);

  // Datapath: capture, scan, overrun flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the bitmap buffer is cleared on reset as well, so no stale capture survives a reset.
      buf_q       <= '0;
      img         <= '0;
      pix_count   <= '0;
      out_block_x <= '0;
      out_block_y <= '0;
      r_q         <= '0;
      c_q         <= '0;
      overrun     <= 1'b0;
    end else begin
      overrun <= in_valid && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            buf_q       <= track;
            out_block_x <= block_x;
            out_block_y <= block_y;
            img         <= '0;
            pix_count   <= '0;
            r_q         <= '0;
            c_q         <= '0;
          end
        end
        SCAN: begin
          img[cell_idx] <= cell_bit;
          pix_count     <= pix_count + 8'(cell_bit);
          if (c_q == CNT_W'(GRID - 1)) begin
            c_q <= '0;
            r_q <= last_cell ? '0 : r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_track_pool.sv
// Randomized self-checking bench for track_pool against a pixel-binning reference model.
module tb_track_pool;
  localparam int BLK    = 52;
  localparam int POOL   = 4;
  localparam int GRID   = 13;
  localparam int THRESH = 2;
  localparam int NPIX   = BLK * BLK;
  localparam int NCELL  = GRID * GRID;
  localparam int LAT    = 169;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [NPIX-1:0]  track = '0;
  logic [3:0]       block_x = '0;
  logic [3:0]       block_y = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [NCELL-1:0] img;
  logic [7:0]       pix_count;
  logic [3:0]       out_block_x;
  logic [3:0]       out_block_y;
  logic             busy;
  logic             overrun;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  track_pool #(.BLKSIZE(BLK), .POOL(POOL), .GRID(GRID), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .track(track),
    .block_x(block_x), .block_y(block_y), .out_ready(out_ready),
    .out_valid(out_valid), .img(img), .pix_count(pix_count),
    .out_block_x(out_block_x), .out_block_y(out_block_y),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [NCELL-1:0] got, input logic [NCELL-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bin every set pixel into its output cell, then apply the cell rule
  function automatic logic [NCELL-1:0] model_img(input logic [NPIX-1:0] t);
    int cnt[NCELL];
    logic [NCELL-1:0] m;
    m = '0;
    for (int k = 0; k < NCELL; k++) cnt[k] = 0;
    for (int p = 0; p < NPIX; p++)
      if (t[p]) cnt[((p / BLK) / POOL) * GRID + (p % BLK) / POOL]++;
    for (int k = 0; k < NCELL; k++) begin
`ifdef TRACK_POOL_THRESH_EN
      m[k] = (cnt[k] >= THRESH);
`else
      m[k] = (cnt[k] > 0);
`endif
    end
    return m;
  endfunction

  function automatic logic [NPIX-1:0] rand_track(input int density);
    logic [NPIX-1:0] t;
    for (int p = 0; p < NPIX; p++) t[p] = ($urandom_range(density - 1, 0) == 0);
    return t;
  endfunction

  task automatic start_capture(input logic [NPIX-1:0] t, input logic [3:0] bx, input logic [3:0] by);
    track    = t;
    block_x  = bx;
    block_y  = by;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc;
    check("busy_after_capture", busy, 1'b1);
  endtask

  task automatic wait_result();
    for (int k = 0; k < 400 && !out_valid; k++) @(negedge clk);
    check("latency", cyc - t0, LAT);
  endtask

  task automatic check_result(input logic [NPIX-1:0] t, input logic [3:0] bx, input logic [3:0] by);
    logic [NCELL-1:0] e;
    e = model_img(t);
    check("out_valid", out_valid, 1'b1);
    check("img", img, e);
    check("pix_count", pix_count, $countones(e));
    check("out_block_x", out_block_x, bx);
    check("out_block_y", out_block_y, by);
  endtask

  task automatic stall_and_release(input logic [NPIX-1:0] t, input int n);
    logic [NCELL-1:0] e;
    e = model_img(t);
    out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1'b1);
      check("stall_img", img, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_dropped", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_img_kept", img, e);
    check("idle_count_kept", pix_count, $countones(e));
  endtask

  task automatic full_capture(input logic [NPIX-1:0] t, input logic [3:0] bx, input logic [3:0] by,
                              input int n);
    start_capture(t, bx, by);
    wait_result();
    check_result(t, bx, by);
    stall_and_release(t, n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_img"}, img, '0);
    check({tag, "_count"}, pix_count, 8'd0);
    check({tag, "_bx"}, out_block_x, 4'd0);
    check({tag, "_by"}, out_block_y, 4'd0);
  endtask

  initial begin
    logic [NPIX-1:0] ta, tb;
    bit seen;
    int dens[5] = '{2, 4, 16, 64, 256};

    // Reset with in_valid asserted: capture must be ignored
    rst = 1'b0;
    in_valid = 1'b1;
    track = '1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", busy, 1'b0);

    // Single pixel at bit 0
    ta = '0;
    ta[0] = 1'b1;
    full_capture(ta, 4'd1, 4'd2, 0);

    // All ones, out_ready already high
    ta = '1;
    out_ready = 1'b1;
    start_capture(ta, 4'd5, 4'd7);
    wait_result();
    check_result(ta, 4'd5, 4'd7);
    @(negedge clk);
    check("one_cycle_valid", out_valid, 1'b0);
    out_ready = 1'b0;

    // Bottom-right window only, 20-cycle stall
    ta = '0;
    for (int r = 48; r < 52; r++)
      for (int c = 48; c < 52; c++) ta[r * BLK + c] = 1'b1;
    full_capture(ta, 4'd8, 4'd8, 20);

    // Overrun mid-scan: second bitmap must be ignored
    ta = rand_track(16);
    tb = ~ta;
    start_capture(ta, 4'd3, 4'd4);
    repeat (49) @(negedge clk);
    track = tb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("overrun_pulse", overrun, 1'b1);
    @(negedge clk);
    check("overrun_single", overrun, 1'b0);
    wait_result();
    check_result(ta, 4'd3, 4'd4);
    // Capture attempt in the handshake cycle is also an overrun
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("overrun_in_handshake", overrun, 1'b1);
    check("handshake_valid_drop", out_valid, 1'b0);
    check("handshake_not_captured", busy, 1'b0);
    check("handshake_img_kept", img, model_img(ta));
    tb = rand_track(64);
    full_capture(tb, 4'd6, 4'd0, 2);

    // Reset mid-scan aborts without a valid
    ta = rand_track(4);
    start_capture(ta, 4'd2, 4'd2);
    repeat (99) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset_values("abort");
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_valid_after_abort", seen, 1'b0);
    tb = rand_track(32);
    full_capture(tb, 4'd7, 4'd1, 1);

    // Randomized captures
    for (int n = 0; n < 8; n++) begin
      ta = rand_track(dens[$urandom_range(4, 0)]);
      full_capture(ta, 4'($urandom_range(8, 0)), 4'($urandom_range(8, 0)), $urandom_range(4, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
